// File: rtl/uart_rx_if.sv
// uart_rx_if: serial pin and received-word bus of the UART receiver.
//   rx           serial line into the receiver, idle high
//   rx_data      last good received word
//   rx_valid     one-cycle strobe when rx_data updates
//   rx_frame_err one-cycle strobe when a stop bit is sampled low
//   rx_busy      receiver is inside a frame (not idle)
// master: the receiver itself; slave: the line driver and word consumer.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
) ();
    logic                 rx;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_frame_err;
    logic                 rx_busy;
    modport master (input rx, output rx_data, rx_valid, rx_frame_err, rx_busy);
    modport slave  (output rx, input rx_data, rx_valid, rx_frame_err, rx_busy);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1-style UART receiver (start, DATA_BITS data LSB-first, stop, no parity).
//   clock    system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      uart_rx_if.master: rx in; rx_data, rx_valid, rx_frame_err, rx_busy out
module uart_rx #(
    parameter int BAUD_RATE  = 9600,
    parameter int CLOCK_FREQ = 50000000,
    parameter int DATA_BITS  = 8
) (
    input  logic      clock,
    input  logic      reset_n,
    uart_rx_if.master bus
);
    localparam int BIT_PERIOD = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF_BIT   = BIT_PERIOD / 2;
    localparam int CW         = $clog2(BIT_PERIOD);
    localparam int BW         = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] HALF_END = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_END  = CW'(BIT_PERIOD - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    if (BIT_PERIOD < 4) begin : g_bad_period
        $error("uart_rx: BIT_PERIOD must be at least 4");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t               state_q, state_d;
    logic [1:0]           sync_q, sync_d;
    logic [CW-1:0]        clock_count_q, clock_count_d;
    logic [BW-1:0]        bit_count_q, bit_count_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
    logic                 valid_q, valid_d, err_q, err_d;
    logic                 rx_s;

    assign rx_s = sync_q[1];

    always_comb begin
        sync_d        = {sync_q[0], bus.rx};
        state_d       = state_q;
        clock_count_d = clock_count_q + 1'b1;
        bit_count_d   = bit_count_q;
        shift_d       = shift_q;
        data_d        = data_q;
        valid_d       = 1'b0;
        err_d         = 1'b0;
        case (state_q)
            IDLE: begin
                clock_count_d = '0;
                bit_count_d   = '0;
                if (!rx_s) state_d = START;
            end
            // Mid-start-bit recheck rejects short glitches on the idle line.
            START: if (clock_count_q == HALF_END) begin
                clock_count_d = '0;
                bit_count_d   = '0;
                state_d       = rx_s ? IDLE : DATA;
            end
            DATA: if (clock_count_q == BIT_END) begin
                clock_count_d = '0;
                shift_d       = DATA_BITS'({rx_s, shift_q} >> 1);
                if (bit_count_q == LAST_BIT) state_d = STOP;
                else bit_count_d = bit_count_q + 1'b1;
            end
            STOP: if (clock_count_q == BIT_END) begin
                clock_count_d = '0;
                state_d       = rx_s ? IDLE : BREAK;
                valid_d       = rx_s;
                err_d         = !rx_s;
                if (rx_s) data_d = shift_q;
            end
            // Wait out a held-low line so it never decodes as a stream of zero words.
            BREAK: begin
                clock_count_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            sync_q        <= 2'b11;
            clock_count_q <= '0;
            bit_count_q   <= '0;
            shift_q       <= '0;
            data_q        <= '0;
            valid_q       <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync_q        <= sync_d;
            clock_count_q <= clock_count_d;
            bit_count_q   <= bit_count_d;
            shift_q       <= shift_d;
            data_q        <= data_d;
            valid_q       <= valid_d;
            err_q         <= err_d;
        end
    end

    assign bus.rx_data      = data_q;
    assign bus.rx_valid     = valid_q;
    assign bus.rx_frame_err = err_q;
    assign bus.rx_busy      = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx; a line-sampling model predicts every strobe.
module tb_uart_rx;
    localparam int BP = 16;
    localparam int HB = 8;
    // Sample k looks at the pin level HB + k*BP cycles after the first low cycle;
    // the strobe shows up 3 edges after the stop sample's pin cycle (2 sync flops + FSM edge).
    localparam int STOP_M = HB + 9 * BP;
    localparam int LAT    = STOP_M + 3;

    typedef struct {
        bit          err;
        logic [7:0]  data;
        int unsigned at;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    int unsigned cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    exp_t        sb[$];
    exp_t        mon_e;
    logic        wave[$];
    logic [7:0]  last_good = 8'h00;
    logic        prev_pulse = 1'b0;

    uart_rx_if #(.DATA_BITS(8)) bus ();

    uart_rx #(.BAUD_RATE(10), .CLOCK_FREQ(160), .DATA_BITS(8)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic at(input int m);
        return m < wave.size() ? wave[m] : 1'b1;
    endfunction

    // Frame of t cycles per bit, then `low` cycles held low, then `gap` idle cycles.
    task automatic build(input logic [7:0] d, input logic stop, input int t, input int low, input int gap);
        int b;
        wave.delete();
        for (int m = 0; m < 10 * t; m++) begin
            b = m / t;
            wave.push_back(b == 0 ? 1'b0 : b <= 8 ? d[b-1] : stop);
        end
        repeat (low) wave.push_back(1'b0);
        repeat (gap) wave.push_back(1'b1);
    endtask

    // Receiver as seen from the line: what the pin holds at each sampling instant.
    // When the bit rate is off, that can differ from the byte that was sent.
    function automatic void predict(input int unsigned c0);
        exp_t e;
        if (at(HB) !== 1'b0) return;
        for (int i = 0; i < 8; i++) e.data[i] = at(HB + (i + 1) * BP);
        e.err = !at(STOP_M);
        if (e.err) e.data = last_good;
        else last_good = e.data;
        e.at = c0 + LAT;
        sb.push_back(e);
    endfunction

    task automatic drive(input bit model, input int upto);
        for (int m = 0; m < wave.size() && m < upto; m++) begin
            @(posedge clock);
            #1;
            if (m == 0 && model) predict(cyc);
            bus.rx = wave[m];
        end
    endtask

    task automatic send(input logic [7:0] d, input logic stop, input int t, input int low, input int gap);
        build(d, stop, t, low, gap);
        drive(1'b1, wave.size());
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && sb.size() != 0; i++) @(posedge clock);
        #1;
        chk("pending_strobes", sb.size(), 0);
    endtask

    always @(negedge clock) begin
        if (reset_n && (bus.rx_valid || bus.rx_frame_err)) begin
            chk("valid_err_exclusive", bus.rx_valid & bus.rx_frame_err, 1'b0);
            chk("strobe_back_to_back", prev_pulse, 1'b0);
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_strobe: valid=%0b err=%0b data=0x%0h, expected none (cycle %0d)",
                         bus.rx_valid, bus.rx_frame_err, bus.rx_data, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("strobe_kind_err", bus.rx_frame_err, mon_e.err);
                chk("strobe_cycle", cyc, mon_e.at);
                chk("rx_data", bus.rx_data, mon_e.data);
                chk("busy_at_strobe", bus.rx_busy, mon_e.err);
            end
        end
        prev_pulse <= reset_n && (bus.rx_valid || bus.rx_frame_err);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_n;
        bus.rx = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_rx_data", bus.rx_data, 8'h00);
        chk("reset_rx_valid", bus.rx_valid, 1'b0);
        chk("reset_rx_frame_err", bus.rx_frame_err, 1'b0);
        chk("reset_rx_busy", bus.rx_busy, 1'b0);
        reset_n = 1'b1;
        repeat (5) @(posedge clock);

        send(8'hA5, 1'b1, BP, 0, 4);
        drain();
        chk("a5_held", bus.rx_data, 8'hA5);
        chk("a5_idle_after", bus.rx_busy, 1'b0);

        busy_n = 0;
        for (int i = 0; i < 24; i++) begin
            @(posedge clock);
            #1;
            bus.rx = i >= 4;
            @(negedge clock);
            if (bus.rx_busy) busy_n++;
        end
        chk("glitch_busy_len", busy_n >= HB && busy_n <= HB + 1, 1'b1);
        chk("glitch_data_held", bus.rx_data, 8'hA5);

        send(8'h3C, 1'b0, BP, 40, 0);
        chk("break_busy", bus.rx_busy, 1'b1);
        bus.rx = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        chk("break_released", bus.rx_busy, 1'b0);
        drain();
        chk("break_data_held", bus.rx_data, 8'hA5);

        send(8'h00, 1'b1, BP, 0, 0);
        send(8'hFF, 1'b1, BP, 0, 0);
        send(8'h81, 1'b1, BP, 0, 4);
        drain();

        build(8'hC3, 1'b1, BP, 0, 0);
        drive(1'b0, 4 * BP + HB);
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        chk("abort_rx_data", bus.rx_data, 8'h00);
        chk("abort_rx_valid", bus.rx_valid, 1'b0);
        chk("abort_rx_frame_err", bus.rx_frame_err, 1'b0);
        chk("abort_rx_busy", bus.rx_busy, 1'b0);
        bus.rx = 1'b1;
        last_good = 8'h00;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (4) @(posedge clock);
        send(8'h5A, 1'b1, BP, 0, 4);
        drain();
        chk("after_abort", bus.rx_data, 8'h5A);

        send(8'h96, 1'b1, BP - 1, 0, 20);
        drain();
        send(8'h96, 1'b1, BP + 1, 0, 4);
        drain();
        chk("slow_rate_96", bus.rx_data, 8'h96);

        for (int k = 0; k < 12; k++) begin
            logic       stop;
            logic [7:0] d;
            d = 8'($urandom);
            stop = $urandom_range(0, 3) != 0;
            send(d, stop, BP, 0, stop ? $urandom_range(0, 6) : $urandom_range(2, 8));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
